// File: rtl/sdram_wr_arbiter_if.sv
// Write-burst bus between two burst writers, the arbiter and sdram_core.
// The master modport is the arbiter's view; slave is the environment's.
interface sdram_wr_arbiter_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 10
);
  logic                 c0_req;
  logic                 c1_req;
  logic [LEN_BITS-1:0]  c0_len;
  logic [LEN_BITS-1:0]  c1_len;
  logic [ADDR_BITS-1:0] c0_addr;
  logic [ADDR_BITS-1:0] c1_addr;
  logic [DATA_BITS-1:0] c0_data;
  logic [DATA_BITS-1:0] c1_data;
  logic                 c0_data_req;
  logic                 c1_data_req;
  logic                 c0_finish;
  logic                 c1_finish;
  logic                 wr_burst_req;
  logic [LEN_BITS-1:0]  wr_burst_len;
  logic [ADDR_BITS-1:0] wr_burst_addr;
  logic [DATA_BITS-1:0] wr_burst_data;
  logic                 wr_burst_data_req;
  logic                 wr_burst_data_finish;
  logic [1:0]           grant;
  logic                 len_err;

  modport master (
    input  c0_req, c1_req,
    input  c0_len, c1_len,
    input  c0_addr, c1_addr,
    input  c0_data, c1_data,
    output c0_data_req, c1_data_req,
    output c0_finish, c1_finish,
    output wr_burst_req,
    output wr_burst_len,
    output wr_burst_addr,
    output wr_burst_data,
    input  wr_burst_data_req,
    input  wr_burst_data_finish,
    output grant,
    output len_err
  );

  modport slave (
    output c0_req, c1_req,
    output c0_len, c1_len,
    output c0_addr, c1_addr,
    output c0_data, c1_data,
    input  c0_data_req, c1_data_req,
    input  c0_finish, c1_finish,
    input  wr_burst_req,
    input  wr_burst_len,
    input  wr_burst_addr,
    input  wr_burst_data,
    output wr_burst_data_req,
    output wr_burst_data_finish,
    input  grant,
    input  len_err
  );
endinterface

// File: rtl/sdram_wr_arbiter.sv
// Round-robin arbiter sharing the sdram_core write-burst port
// between two burst writers; whole bursts are granted at a time.
module sdram_wr_arbiter #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_wr_arbiter_if.master bus
);

  localparam int CW = LEN_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BURST,
    GAP
  } state_e;

  state_e               state_q;
  logic [1:0]           grant_q;
  logic [1:0]           fin_q;
  logic                 last_q;
  logic                 wreq_q;
  logic                 err_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  logic                 any_req;
  logic                 pick1;
  logic [1:0]           win_oh;
  logic [LEN_BITS-1:0]  win_len;
  logic [ADDR_BITS-1:0] win_addr;

  assign any_req = bus.c0_req | bus.c1_req;

  // On a tie the client not served last wins.
  assign pick1 = (bus.c0_req & bus.c1_req) ? ~last_q
                                           : bus.c1_req;

  assign win_oh   = pick1 ? 2'b10 : 2'b01;
  assign win_len  = pick1 ? bus.c1_len : bus.c0_len;
  assign win_addr = pick1 ? bus.c1_addr : bus.c0_addr;

  // Saturating beat count including the current strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.wr_burst_data_req && !(&cnt_q)) begin
      cnt_d = cnt_q + {{LEN_BITS{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      fin_q   <= 2'b00;
      last_q  <= 1'b1;
      wreq_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      fin_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= win_oh;
            len_q   <= win_len;
            addr_q  <= win_addr;
            cnt_q   <= '0;
            if (win_len == '0) begin
              fin_q   <= win_oh;
              state_q <= GAP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wreq_q  <= 1'b1;
          state_q <= BURST;
        end
        BURST: begin
          cnt_q <= cnt_d;
          if (bus.wr_burst_data_finish) begin
            wreq_q  <= 1'b0;
            fin_q   <= grant_q;
            state_q <= GAP;
            if (cnt_d != {1'b0, len_q}) begin
              err_q <= 1'b1;
            end
          end
        end
        GAP: begin
          grant_q <= 2'b00;
          last_q  <= grant_q[1];
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_burst_req  = wreq_q;
  assign bus.wr_burst_len  = len_q;
  assign bus.wr_burst_addr = addr_q;
  assign bus.grant         = grant_q;
  assign bus.len_err       = err_q;
  assign bus.c0_finish     = fin_q[0];
  assign bus.c1_finish     = fin_q[1];

  assign bus.c0_data_req = bus.wr_burst_data_req & grant_q[0];
  assign bus.c1_data_req = bus.wr_burst_data_req & grant_q[1];

  assign bus.wr_burst_data =
    ({DATA_BITS{grant_q[0]}} & bus.c0_data) |
    ({DATA_BITS{grant_q[1]}} & bus.c1_data);

endmodule
